// File: rtl/cpu_mem_pkg.sv
// Shared types, width defaults and constants for the fetch/data memory-port arbiter.
package cpu_mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // Read data returned to a requester whose transaction was aborted.
   localparam logic [DATA_W_DEF-1:0] ABORT_RDATA = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BUSY_IF = 3'd1,
      BUSY_DM = 3'd2,
      DONE_IF = 3'd3,
      DONE_DM = 3'd4
   } arb_state_t;

   function automatic int ctr_width(input int term);
      return (term > 32'sd255) ? $clog2(term + 32'sd1) : 32'sd8;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory port seen by mem_port_arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              stall_if;
   logic              stall_dm;
   logic              timeout_err;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr,
             mem_wdata, stall_if, stall_dm, timeout_err
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr,
             mem_wdata, stall_if, stall_dm, timeout_err
   );

endinterface

// File: rtl/memarb_timeout_ctr.sv
// BUSY-cycle watchdog counter for mem_port_arbiter; exists only when MEMARB_TIMEOUT_EN
// is defined. tc_o is high while the count equals TERM-1 (the TERM-th waiting cycle).
`ifdef MEMARB_TIMEOUT_EN
module memarb_timeout_ctr #(
   parameter int CNT_W = 8,
   parameter int TERM  = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear has priority so a fresh grant always starts from zero.
   always_comb begin
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CNT_W'(TERM - 32'sd1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data memory stages.
// Optional BUSY watchdog with sticky timeout_err: define MEMARB_TIMEOUT_EN.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave arb_bus
);
   localparam logic [2:0] ST_IDLE    = IDLE;
   localparam logic [2:0] ST_BUSY_IF = BUSY_IF;
   localparam logic [2:0] ST_BUSY_DM = BUSY_DM;
   localparam logic [2:0] ST_DONE_IF = DONE_IF;
   localparam logic [2:0] ST_DONE_DM = DONE_DM;

   logic [2:0]        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              dm_valid_q, dm_valid_d;
   logic              busy_s, ack_s, abort_s, grant_if_s, grant_dm_s;

   // An ack outside BUSY (e.g. a stale one after reset) is dropped here.
   assign busy_s = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_DM);
   assign ack_s  = busy_s & arb_bus.mem_ack;

`ifdef MEMARB_TIMEOUT_EN
   localparam int CNT_W = ctr_width(TIMEOUT_CYC);
   logic tc_s;
   logic err_q, err_d;

   memarb_timeout_ctr #(
      .CNT_W (CNT_W),
      .TERM  (TIMEOUT_CYC)
   ) u_timeout_ctr (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .clr_i  (grant_if_s | grant_dm_s),
      .en_i   (busy_s & ~arb_bus.mem_ack),
      .tc_o   (tc_s)
   );

   assign abort_s = busy_s & ~arb_bus.mem_ack & tc_s;
   assign err_d   = err_q | abort_s;

   // Sticky abort flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign arb_bus.timeout_err = err_q;
`else
   logic unused_timeout_s;
   assign unused_timeout_s    = (TIMEOUT_CYC == 32'sd0);
   assign abort_s             = 1'b0;
   assign arb_bus.timeout_err = 1'b0;
`endif

   // Grant sequencing; DM wins in IDLE, and a DONE state only considers the other port.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_bus.dm_req) begin
               state_d = ST_BUSY_DM;
            end else if (arb_bus.if_req) begin
               state_d = ST_BUSY_IF;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY_IF: begin
            if (ack_s || abort_s) state_d = ST_DONE_IF;
            else                  state_d = ST_BUSY_IF;
         end
         ST_BUSY_DM: begin
            if (ack_s || abort_s) state_d = ST_DONE_DM;
            else                  state_d = ST_BUSY_DM;
         end
         ST_DONE_IF: begin
            if (arb_bus.dm_req) state_d = ST_BUSY_DM;
            else                state_d = ST_IDLE;
         end
         ST_DONE_DM: begin
            if (arb_bus.if_req) state_d = ST_BUSY_IF;
            else                state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign grant_if_s = (state_d == ST_BUSY_IF) && (state_q != ST_BUSY_IF);
   assign grant_dm_s = (state_d == ST_BUSY_DM) && (state_q != ST_BUSY_DM);

   // Memory-side fields are latched at grant so they stay stable through BUSY.
   always_comb begin
      mem_req_d   = (state_d == ST_BUSY_IF) || (state_d == ST_BUSY_DM);
      if_valid_d  = (state_d == ST_DONE_IF);
      dm_valid_d  = (state_d == ST_DONE_DM);
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = mem_we_q;
      if (grant_dm_s) begin
         mem_addr_d  = arb_bus.dm_addr;
         mem_wdata_d = arb_bus.dm_wdata;
         mem_we_d    = arb_bus.dm_we;
      end else if (grant_if_s) begin
         mem_addr_d  = arb_bus.if_addr;
         mem_we_d    = 1'b0;
      end else if (!mem_req_d) begin
         mem_we_d    = 1'b0;
      end else begin
         mem_we_d    = mem_we_q;
      end

      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if (abort_s) begin
         if (state_q == ST_BUSY_IF) if_rdata_d = DATA_W'(ABORT_RDATA);
         else                       dm_rdata_d = DATA_W'(ABORT_RDATA);
      end else if (ack_s && !mem_we_q) begin
         if (state_q == ST_BUSY_IF) if_rdata_d = arb_bus.mem_rdata;
         else                       dm_rdata_d = arb_bus.mem_rdata;
      end else begin
         if_rdata_d = if_rdata_q;
         dm_rdata_d = dm_rdata_q;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         if_rdata_q  <= {DATA_W{1'b0}};
         dm_rdata_q  <= {DATA_W{1'b0}};
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
      end
   end

   assign arb_bus.mem_req   = mem_req_q;
   assign arb_bus.mem_we    = mem_we_q;
   assign arb_bus.mem_addr  = mem_addr_q;
   assign arb_bus.mem_wdata = mem_wdata_q;
   assign arb_bus.if_rdata  = if_rdata_q;
   assign arb_bus.dm_rdata  = dm_rdata_q;
   assign arb_bus.if_valid  = if_valid_q;
   assign arb_bus.dm_valid  = dm_valid_q;
   // Stalls drop combinationally in the valid cycle so the pipeline advances on that edge.
   assign arb_bus.stall_if  = arb_bus.if_req & ~if_valid_q;
   assign arb_bus.stall_dm  = arb_bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, timeout/reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
   import cpu_mem_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .arb_bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd, input logic ack,
                        input logic [31:0] rd);
      bus.if_req    = ir;
      bus.if_addr   = ia;
      bus.dm_req    = dr;
      bus.dm_we     = dwe;
      bus.dm_addr   = da;
      bus.dm_wdata  = dwd;
      bus.mem_ack   = ack;
      bus.mem_rdata = rd;
   endtask

   typedef struct {
      logic ir; logic [31:0] ia; logic dr; logic dwe; logic [31:0] da; logic [31:0] dwd;
      logic ack; logic [31:0] rd;
      logic e_mreq; logic e_mwe; logic [31:0] e_maddr; logic [31:0] e_mwdata;
      logic e_ifv; logic e_dmv; logic [31:0] e_ifrd; logic [31:0] e_dmrd;
      logic e_sif; logic e_sdm;
   } vec_t;

   function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dwe, logic [31:0] da,
                               logic [31:0] dwd, logic ack, logic [31:0] rd,
                               logic mreq, logic mwe, logic [31:0] maddr, logic [31:0] mwd,
                               logic ifv, logic dmv, logic [31:0] ifrd, logic [31:0] dmrd,
                               logic sif, logic sdm);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.ack = ack; v.rd = rd;
      v.e_mreq = mreq; v.e_mwe = mwe; v.e_maddr = maddr; v.e_mwdata = mwd;
      v.e_ifv = ifv; v.e_dmv = dmv; v.e_ifrd = ifrd; v.e_dmrd = dmrd; v.e_sif = sif; v.e_sdm = sdm;
      return v;
   endfunction

   vec_t vecs[19];

   // random-phase requester and model state
   logic        ir, dr, dwe, ack, if_seen, dm_seen;
   logic [31:0] ia, da, dwd, rd;
   int          owner, done, waited;
   logic        cur_we, exp_err;
   logic [31:0] cur_addr, cur_wdata, exp_ifrd, exp_dmrd;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // single fetch
      vecs[0]  = mk(1,32'h10,0,0,0,0,0,0,                    0,0,0,0, 0,0,0,0, 1,0);
      vecs[1]  = mk(1,32'h10,0,0,0,0,1,32'h8C220004,         1,0,32'h10,0, 0,0,0,0, 1,0);
      vecs[2]  = mk(1,32'h10,0,0,0,0,0,0,                    0,0,0,0, 1,0,32'h8C220004,0, 0,0);
      vecs[3]  = mk(0,0,0,0,0,0,0,0,                          0,0,0,0, 0,0,32'h8C220004,0, 0,0);
      // contention: DM first, IF granted straight from DONE_DM
      vecs[4]  = mk(1,32'h30,1,0,32'h40,0,0,0,               0,0,0,0, 0,0,32'h8C220004,0, 1,1);
      vecs[5]  = mk(1,32'h30,1,0,32'h40,0,0,0,               1,0,32'h40,0, 0,0,32'h8C220004,0, 1,1);
      vecs[6]  = mk(1,32'h30,1,0,32'h40,0,1,32'hDEAD0040,    1,0,32'h40,0, 0,0,32'h8C220004,0, 1,1);
      vecs[7]  = mk(1,32'h30,1,0,32'h40,0,0,0,               0,0,0,0, 0,1,32'h8C220004,32'hDEAD0040, 1,0);
      vecs[8]  = mk(1,32'h30,0,0,0,0,0,0,                    1,0,32'h30,0, 0,0,32'h8C220004,32'hDEAD0040, 1,0);
      vecs[9]  = mk(1,32'h30,0,0,0,0,1,32'hCAFE0030,         1,0,32'h30,0, 0,0,32'h8C220004,32'hDEAD0040, 1,0);
      vecs[10] = mk(1,32'h30,0,0,0,0,0,0,                    0,0,0,0, 1,0,32'hCAFE0030,32'hDEAD0040, 0,0);
      vecs[11] = mk(0,0,0,0,0,0,0,0,                          0,0,0,0, 0,0,32'hCAFE0030,32'hDEAD0040, 0,0);
      // store: fields held until ack, dm_rdata untouched
      vecs[12] = mk(0,0,1,1,32'h20,32'h12345678,0,0,         0,0,0,0, 0,0,32'hCAFE0030,32'hDEAD0040, 0,1);
      vecs[13] = mk(0,0,1,1,32'h20,32'h12345678,0,0,         1,1,32'h20,32'h12345678, 0,0,32'hCAFE0030,32'hDEAD0040, 0,1);
      vecs[14] = mk(0,0,1,1,32'h20,32'h12345678,0,0,         1,1,32'h20,32'h12345678, 0,0,32'hCAFE0030,32'hDEAD0040, 0,1);
      vecs[15] = mk(0,0,1,1,32'h20,32'h12345678,1,32'hBADBAD00, 1,1,32'h20,32'h12345678, 0,0,32'hCAFE0030,32'hDEAD0040, 0,1);
      vecs[16] = mk(0,0,1,1,32'h20,32'h12345678,0,0,         0,0,0,0, 0,1,32'hCAFE0030,32'hDEAD0040, 0,0);
      // stray ack while idle is ignored
      vecs[17] = mk(0,0,0,0,0,0,1,32'h55555555,              0,0,0,0, 0,0,32'hCAFE0030,32'hDEAD0040, 0,0);
      vecs[18] = mk(0,0,0,0,0,0,0,0,                          0,0,0,0, 0,0,32'hCAFE0030,32'hDEAD0040, 0,0);

      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #12;
      chk1("reset mem_req", bus.mem_req, 1'b0);
      chk1("reset mem_we", bus.mem_we, 1'b0);
      chk32("reset mem_addr", bus.mem_addr, 32'h0);
      chk32("reset mem_wdata", bus.mem_wdata, 32'h0);
      chk1("reset if_valid", bus.if_valid, 1'b0);
      chk1("reset dm_valid", bus.dm_valid, 1'b0);
      chk32("reset if_rdata", bus.if_rdata, 32'h0);
      chk32("reset dm_rdata", bus.dm_rdata, 32'h0);
      chk1("reset timeout_err", bus.timeout_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed vector table
      for (int i = 0; i < 19; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd,
               vecs[i].ack, vecs[i].rd);
         @(negedge clk);
         chk1($sformatf("vec%0d mem_req", i), bus.mem_req, vecs[i].e_mreq);
         if (vecs[i].e_mreq) begin
            chk1($sformatf("vec%0d mem_we", i), bus.mem_we, vecs[i].e_mwe);
            chk32($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].e_maddr);
         end
         if (vecs[i].e_mwe) chk32($sformatf("vec%0d mem_wdata", i), bus.mem_wdata, vecs[i].e_mwdata);
         chk1($sformatf("vec%0d if_valid", i), bus.if_valid, vecs[i].e_ifv);
         chk1($sformatf("vec%0d dm_valid", i), bus.dm_valid, vecs[i].e_dmv);
         chk32($sformatf("vec%0d if_rdata", i), bus.if_rdata, vecs[i].e_ifrd);
         chk32($sformatf("vec%0d dm_rdata", i), bus.dm_rdata, vecs[i].e_dmrd);
         chk1($sformatf("vec%0d stall_if", i), bus.stall_if, vecs[i].e_sif);
         chk1($sformatf("vec%0d stall_dm", i), bus.stall_dm, vecs[i].e_sdm);
      end

      // fetch with no ack ever
      @(posedge clk); #1;
      drive(1, 32'h44, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk1("to grant cycle mem_req", bus.mem_req, 1'b0);
      for (int k = 1; k <= TO; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk1($sformatf("to busy%0d mem_req", k), bus.mem_req, 1'b1);
         chk1($sformatf("to busy%0d if_valid", k), bus.if_valid, 1'b0);
         chk1($sformatf("to busy%0d timeout_err", k), bus.timeout_err, 1'b0);
      end
`ifdef MEMARB_TIMEOUT_EN
      @(posedge clk); #1;
      @(negedge clk);
      chk1("to abort if_valid", bus.if_valid, 1'b1);
      chk32("to abort if_rdata", bus.if_rdata, 32'h0);
      chk1("to abort timeout_err", bus.timeout_err, 1'b1);
      chk1("to abort mem_req", bus.mem_req, 1'b0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk1("to sticky timeout_err", bus.timeout_err, 1'b1);
         chk1("to sticky if_valid", bus.if_valid, 1'b0);
         @(posedge clk); #1;
      end
`else
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk1("wait mem_req", bus.mem_req, 1'b1);
         chk1("wait if_valid", bus.if_valid, 1'b0);
         chk1("wait timeout_err", bus.timeout_err, 1'b0);
         chk1("wait stall_if", bus.stall_if, 1'b1);
      end
`endif

      // reset while a fetch is in BUSY, then a late ack arrives in IDLE
      @(posedge clk); #1;
      drive(1, 32'h48, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("rst pre mem_req", bus.mem_req, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("rst mid mem_req", bus.mem_req, 1'b0);
      chk1("rst mid mem_we", bus.mem_we, 1'b0);
      chk32("rst mid mem_addr", bus.mem_addr, 32'h0);
      chk32("rst mid mem_wdata", bus.mem_wdata, 32'h0);
      chk32("rst mid if_rdata", bus.if_rdata, 32'h0);
      chk32("rst mid dm_rdata", bus.dm_rdata, 32'h0);
      chk1("rst mid timeout_err", bus.timeout_err, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 1, 32'h77777777);
      @(negedge clk);
      chk1("late ack mem_req", bus.mem_req, 1'b0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk1("late ack if_valid", bus.if_valid, 1'b0);
      chk1("late ack dm_valid", bus.dm_valid, 1'b0);
      chk32("late ack if_rdata", bus.if_rdata, 32'h0);
      chk32("late ack dm_rdata", bus.dm_rdata, 32'h0);

      // randomized traffic; model tracks which port owns the memory and which port completes
      ir = 1'b0; dr = 1'b0; dwe = 1'b0; ia = 32'h0; da = 32'h0; dwd = 32'h0;
      if_seen = 1'b0; dm_seen = 1'b0;
      owner = 0; done = 0; waited = 0;
      cur_we = 1'b0; cur_addr = 32'h0; cur_wdata = 32'h0;
      exp_ifrd = 32'h0; exp_dmrd = 32'h0; exp_err = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (if_seen) ir = 1'b0;
         if (dm_seen) dr = 1'b0;
         if (!ir && ($urandom_range(0, 2) == 0)) begin
            ir = 1'b1;
            ia = $urandom & 32'hFFFF_FFFC;
         end
         if (!dr && ($urandom_range(0, 3) == 0)) begin
            dr  = 1'b1;
            dwe = 1'($urandom_range(0, 1));
            da  = $urandom;
            dwd = $urandom;
         end
         ack = ($urandom_range(0, 9) < 32'd4);
         rd  = $urandom;
         drive(ir, ia, dr, dwe, da, dwd, ack, rd);
         @(negedge clk);
         chk1("rnd mem_req", bus.mem_req, owner != 0);
         if (owner != 0) begin
            chk32("rnd mem_addr", bus.mem_addr, cur_addr);
            chk1("rnd mem_we", bus.mem_we, cur_we);
            if (cur_we) chk32("rnd mem_wdata", bus.mem_wdata, cur_wdata);
         end
         chk1("rnd if_valid", bus.if_valid, done == 1);
         chk1("rnd dm_valid", bus.dm_valid, done == 2);
         chk32("rnd if_rdata", bus.if_rdata, exp_ifrd);
         chk32("rnd dm_rdata", bus.dm_rdata, exp_dmrd);
         chk1("rnd stall_if", bus.stall_if, ir && (done != 1));
         chk1("rnd stall_dm", bus.stall_dm, dr && (done != 2));
         chk1("rnd timeout_err", bus.timeout_err, exp_err);
         if_seen = bus.if_valid;
         dm_seen = bus.dm_valid;

         if (owner != 0) begin
            if (ack) begin
               if (!cur_we) begin
                  if (owner == 1) exp_ifrd = rd;
                  else            exp_dmrd = rd;
               end
               done  = owner;
               owner = 0;
            end else begin
               waited++;
               done = 0;
`ifdef MEMARB_TIMEOUT_EN
               if (waited == TO) begin
                  if (owner == 1) exp_ifrd = 32'h0;
                  else            exp_dmrd = 32'h0;
                  exp_err = 1'b1;
                  done    = owner;
                  owner   = 0;
               end
`endif
            end
         end else begin
            if (dr && done != 2) begin
               owner = 2; cur_addr = da; cur_we = dwe; cur_wdata = dwd;
            end else if (ir && done != 1) begin
               owner = 1; cur_addr = ia; cur_we = 1'b0;
            end
            waited = 0;
            done   = 0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
